bnn_channel_mux: RTL and testbench

Registered, parametrised N:1 feature-map channel multiplexer with a valid/ready handshake on input and output. In direct mode it selects one channel per input beat. In scan mode it captures the whole channel vector and serialises all channels in index order. It sits between a binarized convolution/feature-map stage and the downstream XNOR-popcount stage, replacing the fixed combinational 4:1 selector used in earlier layers.

---
 rtl/bnn_channel_mux.sv | 137 +++++++++++++
 tb/tb_bnn_channel_mux.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_channel_mux.sv
// Registered N:1 feature-map channel mux: direct mode picks one channel per beat,
// scan mode serialises the whole vector. Optional sel_err port under `MUX_ERR_EN.
module bnn_channel_mux #(
  parameter  int CHANNELS = 4,
  parameter  int WIDTH    = 1,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] channel,
  input  logic [SEL_W-1:0]          sign,
  input  logic                      mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          outMap,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_last,
`ifdef MUX_ERR_EN
  output logic                      sel_err,
`endif
  output logic [1:0]                o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [SEL_W-1:0]            r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CHANNELS*WIDTH-1:0]   r_hold, w_hold_nxt;
  logic [WIDTH-1:0]            r_out_map, w_map_nxt;
  logic [SEL_W-1:0]            r_out_sel, w_sel_nxt;
  logic                        r_out_last, w_last_nxt;
  logic                        w_in_hs, w_out_hs;
`ifdef MUX_ERR_EN
  logic                        r_sel_err, w_err_nxt, w_sign_bad;
`endif

  // Out-of-range indices match no channel, so they select zero.
  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] vec,
                                            input logic [SEL_W-1:0] idx);
    pick = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) pick = vec[k*WIDTH +: WIDTH];
    end
  endfunction

  // Handshakes: a beat moves on a rising edge only when valid and ready are both high;
  // valid never waits on ready, and in_ready only opens when the output slot frees up.
  assign out_valid = (r_state != ST_IDLE);
  assign in_ready  = rst_n & (~out_valid | (out_ready & r_out_last));
  assign w_in_hs   = in_valid & in_ready;
  assign w_out_hs  = out_valid & out_ready;
  assign w_cnt_inc = r_cnt + SEL_W'(1);

  assign outMap      = r_out_map;
  assign out_sel     = r_out_sel;
  assign out_last    = r_out_last;
  assign o_dbg_state = r_state;
`ifdef MUX_ERR_EN
  assign sel_err     = r_sel_err;
  assign w_sign_bad  = (int'(sign) >= CHANNELS);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    w_map_nxt   = r_out_map;
    w_sel_nxt   = r_out_sel;
    w_last_nxt  = r_out_last;
`ifdef MUX_ERR_EN
    w_err_nxt   = r_sel_err;
`endif
    if (w_in_hs) begin
      if (!mode) begin
        w_state_nxt = ST_DIRECT;
        w_cnt_nxt   = '0;
        w_map_nxt   = pick(channel, sign);
        w_sel_nxt   = sign;
        w_last_nxt  = 1'b1;
`ifdef MUX_ERR_EN
        w_err_nxt   = w_sign_bad;
`endif
      end else begin
        w_state_nxt = ST_SCAN;
        w_cnt_nxt   = '0;
        w_hold_nxt  = channel;
        w_map_nxt   = channel[WIDTH-1:0];
        w_sel_nxt   = '0;
        w_last_nxt  = (CHANNELS == 1);
`ifdef MUX_ERR_EN
        w_err_nxt   = 1'b0;
`endif
      end
    end else if (w_out_hs) begin
      if (r_out_last) begin
        w_state_nxt = ST_IDLE;
      end else begin
        // Only a scan beat can be non-last; advance to the next held channel.
        w_cnt_nxt  = w_cnt_inc;
        w_map_nxt  = pick(r_hold, w_cnt_inc);
        w_sel_nxt  = w_cnt_inc;
        w_last_nxt = (w_cnt_inc == SEL_W'(CHANNELS-1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_out_map  <= '0;
      r_out_sel  <= '0;
      r_out_last <= 1'b0;
`ifdef MUX_ERR_EN
      r_sel_err  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hold     <= w_hold_nxt;
      r_out_map  <= w_map_nxt;
      r_out_sel  <= w_sel_nxt;
      r_out_last <= w_last_nxt;
`ifdef MUX_ERR_EN
      r_sel_err  <= w_err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bnn_channel_mux.sv
// Scoreboard bench for bnn_channel_mux: a 4-channel/2-bit instance for streaming
// checks and a 3-channel/1-bit instance for out-of-range direct selects.
module tb_bnn_channel_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, mode, out_valid, out_ready, out_last;
  logic [7:0] channel;
  logic [1:0] sign, out_sel, out_map, dbg_state;
`ifdef MUX_ERR_EN
  logic       sel_err, sel_err3;
`endif

  logic       in_valid3, in_ready3, mode3, out_valid3, out_ready3, out_last3;
  logic [2:0] channel3;
  logic [1:0] sign3, out_sel3, dbg_state3;
  logic [0:0] out_map3;

  logic [4:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         n_bubble = 0;
  bit         rand_done;
  int         waits;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd2;

  always #5 clk = ~clk;

  bnn_channel_mux #(.CHANNELS(4), .WIDTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .channel(channel), .sign(sign), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .outMap(out_map), .out_sel(out_sel), .out_last(out_last),
`ifdef MUX_ERR_EN
    .sel_err(sel_err),
`endif
    .o_dbg_state(dbg_state)
  );

  bnn_channel_mux #(.CHANNELS(3), .WIDTH(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .channel(channel3), .sign(sign3), .mode(mode3), .out_valid(out_valid3),
    .out_ready(out_ready3), .outMap(out_map3), .out_sel(out_sel3), .out_last(out_last3),
`ifdef MUX_ERR_EN
    .sel_err(sel_err3),
`endif
    .o_dbg_state(dbg_state3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: expected {outMap, out_sel, out_last} beats for one accepted vector.
  task automatic push_exp(input logic [7:0] ch, input logic [1:0] sg, input logic md);
    logic [7:0] c;
    c = ch;
    if (md) begin
      for (int k = 0; k < 4; k++) exp_q.push_back({c[k*2 +: 2], 2'(k), (k == 3)});
    end else begin
      exp_q.push_back({c[sg*2 +: 2], sg, 1'b1});
    end
  endtask

  task automatic send(input logic [7:0] ch, input logic [1:0] sg, input logic md,
                      output int n_wait);
    logic hs;
    in_valid = 1'b1;
    channel  = ch;
    sign     = sg;
    mode     = md;
    n_wait   = 0;
    hs       = 1'b0;
    while (!hs) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (!hs) begin
        n_wait++;
        if (n_wait > 60) begin
          check_eq("send_timeout", n_wait, 0);
          break;
        end
      end
    end
    if (hs) push_exp(ch, sg, md);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
    check_eq("drain_idle", out_valid, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every output handshake against the queue head, and counts
  // cycles where downstream is ready and beats are owed but none is presented.
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst_n && out_valid && out_ready) begin
      check_eq("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("beat", {out_map, out_sel, out_last}, e);
      end
    end
    if (rst_n && out_ready && !out_valid && exp_q.size() != 0) n_bubble++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; channel = '0; sign = '0; mode = 1'b0; out_ready = 1'b1;
    in_valid3 = 1'b0; channel3 = '0; sign3 = '0; mode3 = 1'b0; out_ready3 = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    tick();

    // Direct sweep: ch0..ch3 = 0,1,0,1 back-to-back.
    for (int s = 0; s < 4; s++) begin
      send(8'b01_00_01_00, 2'(s), 1'b0, waits);
      check_eq("dir_ready", waits, 0);
    end
    drain();

    // Scan: beats 0..3, in_ready low until the last beat.
    send(8'b11_10_01_00, 2'd1, 1'b1, waits);
    check_eq("scan_state", dbg_state, ST_SCAN);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      check_eq("scan_busy", in_ready, 0);
      tick();
    end
    @(negedge clk);
    check_eq("scan_last_rdy", in_ready, 1);
    tick();
    drain();

    // Backpressure at beat 1 with a changed vector offered.
    send(8'b11_10_01_00, 2'd0, 1'b1, waits);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    channel   = 8'b00_00_11_11;
    mode      = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      check_eq("bp_map", out_map, 1);
      check_eq("bp_sel", out_sel, 1);
      check_eq("bp_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Back-to-back scans: second accepted on the first's last beat.
    send(8'b00_01_10_11, 2'd0, 1'b1, waits);
    send(8'b10_11_00_01, 2'd0, 1'b1, waits);
    check_eq("b2b_waits", waits, 3);
    drain();
    check_eq("no_bubble", n_bubble, 0);

    // Reset for 2 cycles mid-scan.
    send(8'b11_10_01_00, 2'd0, 1'b1, waits);
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    tick();
    @(negedge clk);
    check_eq("mid_rst_out", {out_valid, out_map, out_sel, out_last}, 0);
    check_eq("mid_rst_ready", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("post_rst_ready", in_ready, 1);
    check_eq("post_rst_valid", out_valid, 0);
    tick();

    // CHANNELS=3: out-of-range select yields zero data, index echoed.
    in_valid3 = 1'b1; channel3 = 3'b111; sign3 = 2'd3; mode3 = 1'b0;
    @(negedge clk);
    check_eq("c3_ready", in_ready3, 1);
    tick();
    check_eq("c3_oor", {out_valid3, out_map3, out_sel3, out_last3}, {1'b1, 1'b0, 2'd3, 1'b1});
`ifdef MUX_ERR_EN
    check_eq("c3_err_hi", sel_err3, 1);
`endif
    sign3 = 2'd2;
    tick();
    in_valid3 = 1'b0;
    check_eq("c3_inrange", {out_valid3, out_map3, out_sel3, out_last3}, {1'b1, 1'b1, 2'd2, 1'b1});
`ifdef MUX_ERR_EN
    check_eq("c3_err_lo", sel_err3, 0);
`endif
    tick();
    check_eq("c3_idle", out_valid3, 0);

    // Random mix with random downstream stalls.
    n_bubble  = 0;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), waits);
          repeat ($urandom_range(0, 2)) tick();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          tick();
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    check_eq("rand_no_bubble", n_bubble, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
